// File: rtl/stack_pkg.sv
// Shared encodings and default stack-region constants for the stack pointer controller.
package stack_pkg;

  localparam int unsigned AW_DEF       = 16;
  localparam logic [15:0] SP_INIT_DEF  = 16'h018F;
  localparam logic [15:0] SP_LIMIT_DEF = 16'h0100;
  localparam int unsigned MAXN_DEF     = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PUSH = 2'd1,
    ST_POP  = 2'd2
  } state_t;

endpackage

// File: rtl/stack_bound_chk.sv
// Combinational legality check for push/pop bursts, evaluated one bit wider than SP
// so that neither the subtraction nor the addition can wrap.
module stack_bound_chk
  import stack_pkg::*;
#(
  parameter int unsigned   AW       = AW_DEF,
  parameter logic [AW-1:0] SP_INIT  = AW'(SP_INIT_DEF),
  parameter logic [AW-1:0] SP_LIMIT = AW'(SP_LIMIT_DEF),
  parameter int unsigned   MAXN     = MAXN_DEF,
  parameter int unsigned   CW       = $clog2(MAXN + 1)
) (
  input  logic [AW-1:0] sp,
  input  logic [CW-1:0] count,
  output logic          push_ok,
  output logic          pop_ok
);

  localparam int unsigned EW = AW + 1;

  logic [EW-1:0] sp_e;
  logic [EW-1:0] cnt_e;
  logic [EW-1:0] lim_e;
  logic [EW-1:0] init_e;
  logic          cnt_ok;

  assign sp_e   = EW'(sp);
  assign cnt_e  = EW'(count);
  assign lim_e  = EW'(SP_LIMIT);
  assign init_e = EW'(SP_INIT);
  assign cnt_ok = (32'(count) <= MAXN);

  // sp - count >= limit is rewritten as sp >= limit + count to stay wrap-free
  assign push_ok = cnt_ok && (sp_e >= (lim_e + cnt_e));
  assign pop_ok  = cnt_ok && ((sp_e + cnt_e) <= init_e);

endmodule

// File: rtl/stack_ctrl.sv
// Stack pointer controller: owns SP, runs multi-word push/pop bursts with one memory
// access per cycle, and guards the stack region with sticky overflow/underflow flags.
module stack_ctrl
  import stack_pkg::*;
#(
  parameter int unsigned   AW       = AW_DEF,
  parameter logic [AW-1:0] SP_INIT  = AW'(SP_INIT_DEF),
  parameter logic [AW-1:0] SP_LIMIT = AW'(SP_LIMIT_DEF),
  parameter int unsigned   MAXN     = MAXN_DEF,
  parameter int unsigned   CW       = $clog2(MAXN + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_req,
  input  logic          pop_req,
  input  logic [CW-1:0] count,
  input  logic          load_sp,
  input  logic [AW-1:0] load_val,
  input  logic          err_clr,
  output logic          ready,
  output logic          busy,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic          mem_re,
  output logic [CW-1:0] word_idx,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] sp_out,
  output logic          full,
  output logic          empty,
  output logic          overflow,
  output logic          underflow
);

  state_t        state;
  logic [CW-1:0] burst_len;
  logic [CW-1:0] next_idx;
  logic          last_word;
  logic          push_ok;
  logic          pop_ok;

  stack_bound_chk #(
    .AW       (AW),
    .SP_INIT  (SP_INIT),
    .SP_LIMIT (SP_LIMIT),
    .MAXN     (MAXN),
    .CW       (CW)
  ) u_bound_chk (
    .sp      (sp_out),
    .count   (count),
    .push_ok (push_ok),
    .pop_ok  (pop_ok)
  );

  assign ready     = (state == ST_IDLE);
  assign busy      = ~ready;
  assign full      = (sp_out == SP_LIMIT);
  assign empty     = (sp_out == SP_INIT);
  assign next_idx  = word_idx + CW'(1);
  assign last_word = (next_idx == burst_len);

  // Each strobe, its address and the matching SP step are registered on the same edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      burst_len <= '0;
      sp_out    <= SP_INIT;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      word_idx  <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      // a flag set later in this block overrides the clear
      if (err_clr) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          mem_we   <= 1'b0;
          mem_re   <= 1'b0;
          mem_addr <= '0;
          word_idx <= '0;
          if (load_sp) begin
            sp_out <= load_val;
          end else if (push_req || pop_req) begin
            if (count == '0) begin
              done <= 1'b1;
            end else if (push_req && !push_ok) begin
              done     <= 1'b1;
              err      <= 1'b1;
              overflow <= 1'b1;
            end else if (!push_req && !pop_ok) begin
              done      <= 1'b1;
              err       <= 1'b1;
              underflow <= 1'b1;
            end else if (push_req) begin
              state     <= ST_PUSH;
              burst_len <= count;
              mem_we    <= 1'b1;
              mem_addr  <= sp_out - AW'(1);
              sp_out    <= sp_out - AW'(1);
              done      <= (count == CW'(1));
            end else begin
              state     <= ST_POP;
              burst_len <= count;
              mem_re    <= 1'b1;
              mem_addr  <= sp_out;
              done      <= (count == CW'(1));
            end
          end
        end
        ST_PUSH: begin
          if (last_word) begin
            state    <= ST_IDLE;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            word_idx <= '0;
          end else begin
            mem_addr <= mem_addr - AW'(1);
            sp_out   <= sp_out - AW'(1);
            word_idx <= next_idx;
            done     <= ((next_idx + CW'(1)) == burst_len);
          end
        end
        ST_POP: begin
          // post-increment: SP moves past the word just read
          sp_out <= sp_out + AW'(1);
          if (last_word) begin
            state    <= ST_IDLE;
            mem_re   <= 1'b0;
            mem_addr <= '0;
            word_idx <= '0;
          end else begin
            mem_addr <= mem_addr + AW'(1);
            word_idx <= next_idx;
            done     <= ((next_idx + CW'(1)) == burst_len);
          end
        end
        default: begin
          state  <= ST_IDLE;
          mem_we <= 1'b0;
          mem_re <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: directed scenarios with literal expectations, then random
// traffic checked every cycle against a per-cycle schedule model of the stack.
module tb_stack_ctrl;

  localparam int unsigned AW   = 16;
  localparam int unsigned MAXN = 4;
  localparam int unsigned CW   = 3;
  localparam int SPI = 'h018F;
  localparam int SPL = 'h0100;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          push_req = 1'b0;
  logic          pop_req = 1'b0;
  logic [CW-1:0] count = '0;
  logic          load_sp = 1'b0;
  logic [AW-1:0] load_val = '0;
  logic          err_clr = 1'b0;
  logic          ready, busy, mem_we, mem_re, done, err, full, empty, overflow, underflow;
  logic [AW-1:0] mem_addr, sp_out;
  logic [CW-1:0] word_idx;

  stack_ctrl dut (
    .clk(clk), .reset(reset), .push_req(push_req), .pop_req(pop_req), .count(count),
    .load_sp(load_sp), .load_val(load_val), .err_clr(err_clr), .ready(ready), .busy(busy),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re), .word_idx(word_idx),
    .done(done), .err(err), .sp_out(sp_out), .full(full), .empty(empty),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // expected outputs for one clock cycle
  typedef struct {
    bit busy, we, re, done, err;
    int addr, idx, sp;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   m_sp;
  bit   m_ovf, m_unf;
  int   n_chk = 0;
  int   n_pass = 0;

  function automatic exp_t idle_rec(input int sp);
    exp_t r;
    r.busy = 0; r.we = 0; r.re = 0; r.done = 0; r.err = 0;
    r.addr = 0; r.idx = 0; r.sp = sp;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // On an accepted request, expand it into the full per-cycle schedule it must produce
  task automatic model_step();
    exp_t r;
    int   n;
    bit   legal;
    if (err_clr) begin m_ovf = 0; m_unf = 0; end
    if (!cur.busy) begin
      n = int'(count);
      if (load_sp) begin
        m_sp = int'(load_val);
      end else if (push_req || pop_req) begin
        legal = push_req ? (n <= MAXN && m_sp - n >= SPL) : (n <= MAXN && m_sp + n <= SPI);
        if (n == 0) begin
          r = idle_rec(m_sp); r.done = 1; q.push_back(r);
        end else if (!legal) begin
          r = idle_rec(m_sp); r.done = 1; r.err = 1; q.push_back(r);
          if (push_req) m_ovf = 1; else m_unf = 1;
        end else begin
          for (int k = 1; k <= n; k++) begin
            r = idle_rec(0);
            r.busy = 1; r.idx = k - 1; r.done = (k == n);
            if (push_req) begin r.we = 1; r.addr = m_sp - k; r.sp = m_sp - k; end
            else begin r.re = 1; r.addr = m_sp + k - 1; r.sp = m_sp + k - 1; end
            q.push_back(r);
          end
          m_sp = push_req ? m_sp - n : m_sp + n;
        end
      end
    end
    cur = (q.size() != 0) ? q.pop_front() : idle_rec(m_sp);
  endtask

  task automatic compare();
    chk("ready", 32'(ready), 32'(!cur.busy));
    chk("busy", 32'(busy), 32'(cur.busy));
    chk("mem_we", 32'(mem_we), 32'(cur.we));
    chk("mem_re", 32'(mem_re), 32'(cur.re));
    chk("done", 32'(done), 32'(cur.done));
    chk("err", 32'(err), 32'(cur.err));
    chk("sp_out", 32'(sp_out), cur.sp);
    chk("full", 32'(full), 32'(cur.sp == SPL));
    chk("empty", 32'(empty), 32'(cur.sp == SPI));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
    if (cur.we || cur.re) begin
      chk("mem_addr", 32'(mem_addr), cur.addr);
      chk("word_idx", 32'(word_idx), cur.idx);
    end
  endtask

  task automatic cycle(input bit pu, input bit po, input int cnt, input bit ld,
                       input int lv, input bit clr);
    push_req = pu; pop_req = po; count = CW'(cnt);
    load_sp = ld; load_val = AW'(lv); err_clr = clr;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
  endtask

  // called at a negedge; reset takes effect immediately, released one cycle later
  task automatic do_reset();
    reset = 1'b0;
    #1;
    q.delete();
    m_sp = SPI; m_ovf = 0; m_unf = 0;
    cur = idle_rec(SPI);
    compare();
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_idx", 32'(word_idx), 0);
    @(negedge clk);
    reset = 1'b1;
    compare();
  endtask

  initial begin
    bit pu, po, ld, clr;
    int cnt, lv, sel;
    cur = idle_rec(SPI); m_sp = SPI; m_ovf = 0; m_unf = 0;
    @(negedge clk);
    do_reset();
    chk("lit_rst_sp", 32'(sp_out), 'h018F);
    chk("lit_rst_empty", 32'(empty), 1);
    chk("lit_rst_ready", 32'(ready), 1);

    cycle(1, 0, 3, 0, 0, 0);
    chk("lit_push_a0", 32'(mem_addr), 'h018E);
    idle(1);
    chk("lit_push_a1", 32'(mem_addr), 'h018D);
    idle(1);
    chk("lit_push_a2", 32'(mem_addr), 'h018C);
    chk("lit_push_idx2", 32'(word_idx), 2);
    chk("lit_push_done", 32'(done), 1);
    chk("lit_push_sp", 32'(sp_out), 'h018C);
    idle(1);
    chk("lit_push_ready", 32'(ready), 1);

    cycle(0, 1, 2, 0, 0, 0);
    chk("lit_pop_a0", 32'(mem_addr), 'h018C);
    idle(1);
    chk("lit_pop_a1", 32'(mem_addr), 'h018D);
    chk("lit_pop_done", 32'(done), 1);
    idle(1);
    chk("lit_pop_sp", 32'(sp_out), 'h018E);
    cycle(0, 1, 2, 0, 0, 0);
    chk("lit_unf_err", 32'({done, err, underflow, mem_re}), 'b1110);
    chk("lit_unf_sp", 32'(sp_out), 'h018E);

    cycle(0, 0, 0, 1, 'h0101, 0);
    cycle(1, 0, 2, 0, 0, 0);
    chk("lit_ovf_err", 32'({done, err, overflow, mem_we}), 'b1110);
    chk("lit_ovf_sp", 32'(sp_out), 'h0101);
    cycle(1, 0, 1, 0, 0, 0);
    chk("lit_lim_addr", 32'(mem_addr), 'h0100);
    idle(1);
    chk("lit_full", 32'(full), 1);
    cycle(0, 0, 0, 0, 0, 1);
    chk("lit_clr", 32'({overflow, underflow}), 0);

    cycle(1, 1, 2, 1, 'h0150, 0);
    chk("lit_load_prio", 32'({done, mem_we, mem_re}), 0);
    chk("lit_load_sp", 32'(sp_out), 'h0150);
    cycle(1, 0, 4, 0, 0, 0);
    cycle(1, 0, 2, 0, 0, 0);
    idle(4);
    chk("lit_busy_ignored", 32'(sp_out), 'h014C);
    cycle(1, 0, 0, 0, 0, 0);
    chk("lit_cnt0", 32'({done, err, mem_we}), 'b100);
    cycle(0, 1, 5, 0, 0, 0);
    chk("lit_cnt5_pop", 32'({done, err, underflow}), 'b111);
    cycle(1, 0, 5, 0, 0, 0);
    chk("lit_cnt5_push", 32'({done, err, overflow}), 'b111);

    cycle(0, 0, 0, 1, 'h018F, 1);
    cycle(1, 0, 4, 0, 0, 0);
    idle(1);
    chk("lit_mid_a1", 32'(mem_addr), 'h018D);
    do_reset();
    chk("lit_mid_rst", 32'({mem_we, ready, sp_out}), {1'b0, 1'b1, 16'h018F});
    cycle(1, 0, 1, 0, 0, 0);
    chk("lit_fresh_addr", 32'(mem_addr), 'h018E);
    idle(2);

    for (int it = 0; it < 3000; it++) begin
      if ($urandom_range(0, 99) < 2) begin
        do_reset();
      end else begin
        pu  = ($urandom_range(0, 99) < 30);
        po  = ($urandom_range(0, 99) < 30);
        ld  = ($urandom_range(0, 99) < 5);
        clr = ($urandom_range(0, 99) < 5);
        cnt = int'($urandom_range(0, 5));
        sel = int'($urandom_range(0, 2));
        lv  = (sel == 0) ? SPL - 2 + int'($urandom_range(0, 8)) :
              (sel == 1) ? SPI - 6 + int'($urandom_range(0, 8)) :
                           int'($urandom_range('h0100, 'h018F));
        cycle(pu, po, cnt, ld, lv, clr);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/stack_ctrl.md
Name: stack_ctrl

Overview:
Parametrised stack-pointer controller and successor to the single-step stack pointer. It owns the SP register and accepts multi-word push/pop bursts (for example CALL pushing PC plus flags) through a ready/done handshake. It generates one data-memory access per cycle and guards the stack region with bounds checks and sticky overflow/underflow flags. It sits between the control unit and the data-memory address mux.

Parameters:
AW, 16, address / SP width
SP_INIT, 16'h018F, reset and empty value of SP (stack grows downward)
SP_LIMIT, 16'h0100, lowest legal SP value (full when SP == SP_LIMIT)
MAXN, 4, maximum words per burst
CW, $clog2(MAXN+1), width of the count field

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
push_req  in  1  start push burst (sampled when ready=1)
pop_req  in  1  start pop burst (sampled when ready=1)
count  in  CW  words in burst
load_sp  in  1  load SP from load_val (sampled when ready=1)
load_val  in  AW  new SP value
err_clr  in  1  clear sticky flags
ready  out  1  controller idle, request accepted this edge
busy  out  1  burst in progress
mem_addr  out  AW  data-memory address for the current word
mem_we  out  1  write strobe (push)
mem_re  out  1  read strobe (pop)
word_idx  out  CW  index of the current word, 0..count-1
done  out  1  one-cycle pulse at end of request
err  out  1  qualifies done: request rejected
sp_out  out  AW  current SP (registered)
full  out  1  sp_out == SP_LIMIT (combinational)
empty  out  1  sp_out == SP_INIT (combinational)
overflow  out  1  sticky, push rejected
underflow  out  1  sticky, pop rejected

Behaviour:
- Reset (async, any time including mid-burst): state=IDLE, sp_out=SP_INIT, ready=1, busy=0, mem_we=mem_re=done=err=0, mem_addr=0, word_idx=0, overflow=underflow=0. The burst is aborted with no further strobes.
- States: IDLE, PUSH, POP. ready = (state==IDLE); busy = !ready.
- Request priority in IDLE: load_sp > push_req > pop_req. Lower-priority requests in the same cycle are dropped.
  - A dropped request gets no done.
  - Requests arriving while busy are ignored.
- load_sp: sp_out = load_val on the next edge. No done pulse, no bounds check.
- All bounds arithmetic is done in AW+1 bits with no wrap.
  - Push is legal iff sp - count >= SP_LIMIT.
  - Pop is legal iff sp + count <= SP_INIT.
  - count > MAXN is illegal. The flag set is overflow for a push and underflow for a pop.
- Illegal request: stays in IDLE. In cycle+1: done=1, err=1, the matching sticky flag is set, no strobes, SP unchanged.
- count==0: stays in IDLE. In cycle+1: done=1, err=0, no strobes.
- Legal push of N words accepted at edge T0 (SP value S): go to PUSH.
  - In cycle k (k=1..N after T0): mem_we=1, mem_addr=S-k, word_idx=k-1. This is pre-decrement addressing.
  - sp_out=S-k is registered with the same edge that presents the strobe.
  - done=1 in cycle N alongside the last strobe. State returns to IDLE, with ready=1 in cycle N+1.
- Legal pop of N words: go to POP.
  - In cycle k: mem_re=1, mem_addr=S+k-1, word_idx=k-1. This is post-increment addressing.
  - sp_out=S+k after the strobe edge. done is pulsed in cycle N.
- Back-to-back: a new request may be sampled in the cycle ready returns high. Minimum burst period is N+1 cycles.
- Sticky flags: err_clr clears them on the next edge. A set on the same edge as err_clr wins.
- Strobes are mutually exclusive and never asserted outside PUSH/POP.

Decomposition:
- Shared package/include (stack_pkg): state encodings ST_IDLE/ST_PUSH/ST_POP and default SP_INIT/SP_LIMIT constants, reused by the control unit.
- One natural sub-module: stack_bound_chk. It is combinational and computes the legal-push/legal-pop checks in AW+1 bits from sp, count, SP_INIT, SP_LIMIT and MAXN. Everything else stays in stack_ctrl.

Test Plan:
- Reset then idle → sp_out=018F, empty=1, full=0, ready=1, all strobes 0, flags 0.
- Push count=3 from 018F → mem_we in three consecutive cycles with addr 018E,018D,018C and word_idx 0,1,2; done in the third cycle; sp_out=018C; ready again in the next cycle.
- Then pop count=2 → mem_re with addr 018C,018D; done in the second cycle; sp_out=018E. Then pop count=2 → underflow=1, done+err, no strobes, sp stays 018E.
- load_sp 0101, push count=2 → overflow=1, err, sp 0101. Push count=1 → addr 0100, full=1. err_clr → flags 0.
- load_sp, push_req and pop_req together in IDLE → only the load takes effect, no done. push_req during busy → ignored. count=0 → done, err=0, no strobes. count=5 (MAXN=4) → err.
- Assert reset in cycle 2 of a 4-word push → strobes drop immediately, sp_out=018F, ready=1; a fresh push works normally afterwards.
